// File: rtl/tfhe_sched_pkg.sv
// Shared types for the TFHE PBS job scheduler: FSM states, descriptor layout, LED map.
package tfhe_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // Descriptor layout as the host register file presents it (32-bit words)
    localparam int JOB_DATA_W = 32;

    typedef struct packed {
        logic [JOB_DATA_W-1:0] addr;
        logic [JOB_DATA_W-1:0] len;
    } job_desc_t;

    localparam int LED_START = 7;
    localparam int LED_BUSY  = 6;
    localparam int LED_OVF   = 5;
    localparam int LED_LVL_W = 5;

endpackage

// File: rtl/tfhe_job_fifo.sv
// First-word-fall-through job descriptor FIFO with flush; push while full succeeds
// only when a pop happens in the same cycle.
module tfhe_job_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level == '0);
    assign full    = (level == LW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            level <= level + LW'(do_push) - LW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/tfhe_job_sched.sv
// PBS job scheduler: queues host descriptors and runs them back-to-back with
// programmable RUN/DRAIN latency emulation, abort, overflow and job accounting.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting; pops queue head when non-empty
//   ST_LOAD  | one cycle: publish descriptor, bump job_id, latch timers
//   ST_RUN   | counts down latched run length
//   ST_DRAIN | counts down latched drain length; last cycle pulses pbs_done
module tfhe_job_sched
    import tfhe_sched_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int QUEUE_DEPTH = 4,
    parameter int CNT_W       = 32,
    parameter int ID_W        = 8
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [DATA_W-1:0]              host_wr_addr,
    input  logic [DATA_W-1:0]              host_wr_len,
    input  logic                           start_pbs,
    input  logic                           abort,
    input  logic                           clr_status,
    input  logic [CNT_W-1:0]               run_cycles,
    input  logic [CNT_W-1:0]               drain_cycles,
    output logic [DATA_W-1:0]              host_rd_addr,
    output logic [DATA_W-1:0]              host_rd_len,
    output logic [ID_W-1:0]                job_id,
    output logic                           pbs_busy,
    output logic                           pbs_done,
    output logic                           pbs_aborted,
    output logic [$clog2(QUEUE_DEPTH):0]   queue_level,
    output logic                           queue_full,
    output logic                           overflow,
    output logic [DATA_W-1:0]              jobs_done,
    output logic [7:0]                     user_led
);

    typedef struct packed {
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] len;
    } job_t;

    state_t           state_q;
    state_t           state_d;
    logic             start_seen;
    logic             abort_q;
    logic             accept;
    logic             push;
    logic             pop;
    logic             drop;
    logic             fifo_empty;
    logic             tc;
    job_t             wr_job;
    job_t             rd_job;
    job_t             hold_job;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] drain_lat;
    logic [31:0]      lvl_ext;

    assign accept = start_pbs && !start_seen && !abort;
    assign pop    = (state_q == ST_IDLE) && !fifo_empty && !abort;
    assign push   = accept && (!queue_full || pop);
    assign drop   = accept && queue_full && !pop;
    assign tc     = (cnt_q == CNT_W'(1));

    assign wr_job.addr = host_wr_addr;
    assign wr_job.len  = host_wr_len;

    tfhe_job_fifo #(
        .WIDTH (2 * DATA_W),
        .DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .wr_data (wr_job),
        .pop     (pop),
        .rd_data (rd_job),
        .flush   (abort),
        .level   (queue_level),
        .full    (queue_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (!fifo_empty) state_d = ST_LOAD;
                ST_LOAD:  state_d = ST_RUN;
                ST_RUN:   if (tc) state_d = ST_DRAIN;
                ST_DRAIN: if (tc) state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // An abort landing on the final drain cycle cancels the completion
    assign pbs_done = (state_q == ST_DRAIN) && tc && !abort;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            start_seen   <= 1'b0;
            abort_q      <= 1'b0;
            pbs_busy     <= 1'b0;
            pbs_aborted  <= 1'b0;
            overflow     <= 1'b0;
            hold_job     <= '0;
            host_rd_addr <= '0;
            host_rd_len  <= '0;
            job_id       <= '0;
            jobs_done    <= '0;
            cnt_q        <= '0;
            drain_lat    <= '0;
        end else begin
            state_q     <= state_d;
            start_seen  <= start_pbs;
            abort_q     <= abort;
            pbs_busy    <= (state_d != ST_IDLE);
            pbs_aborted <= abort && !abort_q;

            if (drop)            overflow <= 1'b1;
            else if (clr_status) overflow <= 1'b0;

            if (pop) hold_job <= rd_job;

            if (!abort) begin
                case (state_q)
                    ST_LOAD: begin
                        host_rd_addr <= hold_job.addr;
                        host_rd_len  <= hold_job.len;
                        job_id       <= job_id + 1'b1;
                        cnt_q        <= (run_cycles == '0) ? CNT_W'(1) : run_cycles;
                        drain_lat    <= (drain_cycles == '0) ? CNT_W'(1) : drain_cycles;
                    end
                    ST_RUN: begin
                        cnt_q <= tc ? drain_lat : cnt_q - 1'b1;
                    end
                    ST_DRAIN: begin
                        if (tc) jobs_done <= jobs_done + 1'b1;
                        else    cnt_q     <= cnt_q - 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign lvl_ext = 32'(queue_level);

    always_comb begin
        user_led                       = '0;
        user_led[LED_START]            = start_pbs;
        user_led[LED_BUSY]             = pbs_busy;
        user_led[LED_OVF]              = overflow;
        user_led[LED_LVL_W-1:0]        = (lvl_ext > 32'd31) ? 5'd31 : lvl_ext[LED_LVL_W-1:0];
    end

endmodule

// File: tb/tb_tfhe_job_sched.sv
// Self-checking bench for tfhe_job_sched: vector table of single jobs plus
// hand-written back-to-back, overflow, abort and async-reset sequences.
module tb_tfhe_job_sched;
    import tfhe_sched_pkg::*;

    localparam int DATA_W      = 32;
    localparam int QUEUE_DEPTH = 4;
    localparam int CNT_W       = 32;
    localparam int ID_W        = 8;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [DATA_W-1:0] host_wr_addr;
    logic [DATA_W-1:0] host_wr_len;
    logic              start_pbs;
    logic              abort;
    logic              clr_status;
    logic [CNT_W-1:0]  run_cycles;
    logic [CNT_W-1:0]  drain_cycles;
    logic [DATA_W-1:0] host_rd_addr;
    logic [DATA_W-1:0] host_rd_len;
    logic [ID_W-1:0]   job_id;
    logic              pbs_busy;
    logic              pbs_done;
    logic              pbs_aborted;
    logic [2:0]        queue_level;
    logic              queue_full;
    logic              overflow;
    logic [DATA_W-1:0] jobs_done;
    logic [7:0]        user_led;

    tfhe_job_sched #(
        .DATA_W      (DATA_W),
        .QUEUE_DEPTH (QUEUE_DEPTH),
        .CNT_W       (CNT_W),
        .ID_W        (ID_W)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .host_wr_addr (host_wr_addr),
        .host_wr_len  (host_wr_len),
        .start_pbs    (start_pbs),
        .abort        (abort),
        .clr_status   (clr_status),
        .run_cycles   (run_cycles),
        .drain_cycles (drain_cycles),
        .host_rd_addr (host_rd_addr),
        .host_rd_len  (host_rd_len),
        .job_id       (job_id),
        .pbs_busy     (pbs_busy),
        .pbs_done     (pbs_done),
        .pbs_aborted  (pbs_aborted),
        .queue_level  (queue_level),
        .queue_full   (queue_full),
        .overflow     (overflow),
        .jobs_done    (jobs_done),
        .user_led     (user_led)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] len;
        logic [31:0] run;
        logic [31:0] drain;
        int          lat;
    } vec_t;

    vec_t      vecs [4];
    job_desc_t sb [$];
    job_desc_t mon_e;
    int        n_checks = 0;
    int        n_pass   = 0;
    int        exp_id   = 0;
    int        exp_jobs = 0;
    int        lat;
    int        ndone;
    int        gaps;
    int        dc [3];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic push_exp(input logic [31:0] a, input logic [31:0] l);
        job_desc_t e;
        e.addr = a;
        e.len  = l;
        sb.push_back(e);
    endtask

    // Scoreboard: every completion must match the oldest expected job
    always @(negedge clk) begin
        if (reset_n && pbs_done) begin
            check("done_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                exp_id++;
                exp_jobs++;
                check("done_addr", 64'(host_rd_addr), 64'(mon_e.addr));
                check("done_len", 64'(host_rd_len), 64'(mon_e.len));
                check("done_id", 64'(job_id), 64'(exp_id % 256));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{32'h1000, 32'h40, 32'd3, 32'd2, 6};
        vecs[1] = '{32'h2000, 32'h11, 32'd0, 32'd0, 3};
        vecs[2] = '{32'h3000, 32'h08, 32'd1, 32'd5, 7};
        vecs[3] = '{32'h4000, 32'h04, 32'd6, 32'd1, 8};

        reset_n = 1'b0; start_pbs = 1'b0; abort = 1'b0; clr_status = 1'b0;
        host_wr_addr = '0; host_wr_len = '0; run_cycles = 32'd1; drain_cycles = 32'd1;
        repeat (2) @(negedge clk);
        check("rst_rd_addr", 64'(host_rd_addr), 0);
        check("rst_job_id", 64'(job_id), 0);
        check("rst_busy", 64'(pbs_busy), 0);
        check("rst_level", 64'(queue_level), 0);
        check("rst_overflow", 64'(overflow), 0);
        check("rst_jobs_done", 64'(jobs_done), 0);
        check("rst_led", 64'(user_led), 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Single jobs from the vector table; timers are disturbed mid-job
        for (int i = 0; i < 4; i++) begin
            run_cycles   = vecs[i].run;
            drain_cycles = vecs[i].drain;
            host_wr_addr = vecs[i].addr;
            host_wr_len  = vecs[i].len;
            start_pbs    = 1'b1;
            push_exp(vecs[i].addr, vecs[i].len);
            lat = -1;
            for (int k = 0; k < 200; k++) begin
                @(negedge clk);
                if (k == 0) check("vec_level_at_pop", 64'(queue_level), 1);
                if (k == 2) begin
                    run_cycles   = 32'd77;
                    drain_cycles = 32'd77;
                end
                if (pbs_done) begin
                    lat = k;
                    break;
                end
            end
            start_pbs = 1'b0;
            check("vec_latency", 64'(lat), 64'(vecs[i].lat));
            repeat (3) @(negedge clk);
            check("vec_jobs_done", 64'(jobs_done), 64'(exp_jobs));
            check("vec_job_id", 64'(job_id), 64'(i + 1));
            check("vec_idle_busy", 64'(pbs_busy), 0);
            check("vec_idle_level", 64'(queue_level), 0);
        end

        // Back-to-back: three pulses, 1-cycle run and drain
        run_cycles = 32'd1; drain_cycles = 32'd1;
        ndone = 0; gaps = 0;
        for (int c = 0; c < 40; c++) begin
            if (pbs_done) begin
                if (ndone < 3) dc[ndone] = c;
                ndone++;
            end else if (!pbs_busy && ndone >= 1 && ndone < 3) begin
                gaps++;
            end
            if (c == 5) begin
                check("b2b_level", 64'(queue_level), 2);
                check("b2b_led_level", 64'(user_led[4:0]), 2);
            end
            start_pbs = (c == 0 || c == 2 || c == 4);
            if (start_pbs) begin
                host_wr_addr = 32'h100 * (c / 2 + 1);
                host_wr_len  = 32'(c + 1);
                push_exp(host_wr_addr, host_wr_len);
            end
            @(negedge clk);
        end
        check("b2b_ndone", 64'(ndone), 3);
        check("b2b_spacing_1", 64'(dc[1] - dc[0]), 4);
        check("b2b_spacing_2", 64'(dc[2] - dc[1]), 4);
        check("b2b_idle_gaps", 64'(gaps), 2);
        check("b2b_final_level", 64'(queue_level), 0);

        // Overflow: six pulses during a long RUN; last one collides with clr_status
        run_cycles = 32'd100; drain_cycles = 32'd1;
        for (int c = 0; c < 12; c++) begin
            start_pbs  = (c % 2 == 0) && (c <= 10);
            clr_status = (c == 10);
            if (start_pbs) begin
                host_wr_addr = 32'h500 + 32'(c);
                host_wr_len  = 32'(c);
                if (c <= 8) push_exp(host_wr_addr, host_wr_len);
            end
            @(negedge clk);
        end
        check("ovf_level", 64'(queue_level), 4);
        check("ovf_full", 64'(queue_full), 1);
        check("ovf_set_wins", 64'(overflow), 1);
        check("ovf_led", 64'(user_led), 64'h64);
        clr_status = 1'b1;
        @(negedge clk);
        clr_status = 1'b0;
        check("ovf_cleared", 64'(overflow), 0);
        check("ovf_led_cleared", 64'(user_led[5]), 0);

        // Abort during RUN with a full queue; a coinciding start is discarded
        abort = 1'b1; start_pbs = 1'b1; host_wr_addr = 32'hdead;
        #1;
        check("abort_led_start", 64'(user_led[7]), 1);
        @(negedge clk);
        abort = 1'b0; start_pbs = 1'b0;
        sb.delete();
        exp_id = exp_id + 1;
        check("abort_pulse", 64'(pbs_aborted), 1);
        check("abort_busy", 64'(pbs_busy), 0);
        check("abort_level", 64'(queue_level), 0);
        check("abort_jobs_done", 64'(jobs_done), 64'(exp_jobs));
        check("abort_job_id", 64'(job_id), 64'(exp_id));
        check("abort_rd_addr", 64'(host_rd_addr), 64'h500);
        @(negedge clk);
        check("abort_pulse_end", 64'(pbs_aborted), 0);
        repeat (20) @(negedge clk);
        check("abort_stay_idle", 64'(pbs_busy), 0);
        check("abort_stay_empty", 64'(queue_level), 0);

        // Asynchronous reset in the middle of DRAIN
        run_cycles = 32'd2; drain_cycles = 32'd20;
        host_wr_addr = 32'h7000; host_wr_len = 32'h70; start_pbs = 1'b1;
        push_exp(host_wr_addr, host_wr_len);
        repeat (8) @(negedge clk);
        start_pbs = 1'b0;
        check("arst_busy_before", 64'(pbs_busy), 1);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        sb.delete();
        exp_id = 0;
        exp_jobs = 0;
        check("arst_busy", 64'(pbs_busy), 0);
        check("arst_rd_addr", 64'(host_rd_addr), 0);
        check("arst_job_id", 64'(job_id), 0);
        check("arst_jobs_done", 64'(jobs_done), 0);
        check("arst_led", 64'(user_led), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        run_cycles = 32'd1; drain_cycles = 32'd1;
        host_wr_addr = 32'h8000; host_wr_len = 32'h80; start_pbs = 1'b1;
        push_exp(host_wr_addr, host_wr_len);
        lat = -1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (pbs_done) begin
                lat = k;
                break;
            end
        end
        start_pbs = 1'b0;
        check("arst_new_latency", 64'(lat), 3);
        repeat (2) @(negedge clk);
        check("arst_new_job_id", 64'(job_id), 1);
        check("arst_new_jobs_done", 64'(jobs_done), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tfhe_job_sched.md
Name: tfhe_job_sched

Overview:
- Parametrised successor to the single-shot PBS management FSM: queues host PBS job descriptors (addr, len) in an internal FIFO and executes them back-to-back.
- Each job is timed by runtime-programmable RUN/DRAIN cycle counts, emulating PBS latency until the real core is attached.
- Adds abort, overflow detection, job IDs and a completed-job counter.
- Sits between the AXI-Lite register file (host side) and the memory-read/PBS datapath (rd side).

Parameters:
- DATA_W, 32, width of addr/len/status words
- QUEUE_DEPTH, 4, job FIFO entries (power of 2, >=2)
- CNT_W, 32, width of run/drain cycle counters
- ID_W, 8, width of job ID (wraps)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- host_wr_addr  in  DATA_W  job source address
- host_wr_len  in  DATA_W  job length
- start_pbs  in  1  level request; one job enqueued per low->high assertion
- abort  in  1  synchronous flush request (pulse or level)
- clr_status  in  1  clears sticky overflow
- run_cycles  in  CNT_W  RUN phase length (0 treated as 1)
- drain_cycles  in  CNT_W  DRAIN phase length (0 treated as 1)
- host_rd_addr  out  DATA_W  address of active job
- host_rd_len  out  DATA_W  length of active job
- job_id  out  ID_W  ID of active/last job
- pbs_busy  out  1  high in LOAD/RUN/DRAIN
- pbs_done  out  1  1-cycle pulse per completed job
- pbs_aborted  out  1  1-cycle pulse on abort
- queue_level  out  $clog2(QUEUE_DEPTH)+1  entries queued
- queue_full  out  1  queue_level==QUEUE_DEPTH
- overflow  out  1  sticky: request dropped while full
- jobs_done  out  DATA_W  completed-job counter (wraps)
- user_led  out  8  [7]=start_pbs, [6]=pbs_busy, [5]=overflow, [4:0]=queue_level saturated at 31

Behaviour:
- Reset: all outputs, FIFO pointers, counters and start_seen are 0; state IDLE. Asynchronous assertion; release is sampled on clk.
- Enqueue: accept when start_pbs && !start_seen, then set start_seen. Clear start_seen in any cycle with start_pbs==0.
  - Accepted request with queue not full: push {host_wr_addr, host_wr_len} sampled that cycle.
  - Accepted request with queue full and no pop in the same cycle: drop it and set overflow.
  - Accepted request with queue full and a pop in the same cycle: push succeeds.
- FSM IDLE -> LOAD -> RUN -> DRAIN -> IDLE:
  - IDLE: if queue non-empty, pop the head and go to LOAD. No pop occurs in any other state.
  - LOAD (1 cycle): host_rd_addr/len <= popped entry; job_id <= job_id+1 (first job ID = 1); latch max(run_cycles,1) and max(drain_cycles,1); go to RUN.
  - RUN: lasts exactly the latched run count in cycles, then DRAIN.
  - DRAIN: lasts exactly the latched drain count. On its final cycle, pbs_done=1 and jobs_done+1, then go to IDLE.
  - Changes to run/drain_cycles mid-job have no effect on the current job.
- Timing: minimum job = 1 LOAD + R + D cycles, plus 1 IDLE cycle between jobs. pbs_done rises exactly 1+R+D cycles after the pop cycle.
- pbs_busy is a registered decode of state. It is low for exactly one IDLE cycle between consecutive queued jobs.
- Abort (highest priority, any state):
  - Next cycle: state=IDLE, FIFO emptied, pbs_aborted=1 for one cycle.
  - No pbs_done, jobs_done unchanged, host_rd_* and job_id hold.
  - An enqueue coinciding with abort is discarded; start_seen is still updated.
- clr_status clears overflow. If clr_status and a new overflow occur in the same cycle, the set wins.
- Counter widths: job_id and jobs_done wrap modulo 2^width. Run/drain counters count down from the latched value and never underflow.

Decomposition:
- Package tfhe_sched_pkg: state enum (IDLE/LOAD/RUN/DRAIN), job descriptor struct {addr, len}, LED bit-index constants.
- Sub-module tfhe_job_fifo: synchronous, first-word-fall-through, parametrised DATA width/DEPTH, with push/pop/level/full/empty. The FSM, edge-detect and counters stay in the top level.

Test Plan:
- Single job: addr=0x1000, len=0x40, run=3, drain=2, start held high 10 cycles -> one LOAD; pbs_done 6 cycles after pop; host_rd_addr=0x1000; job_id=1; jobs_done=1; no second job.
- Back-to-back: 3 start pulses, addrs 0x100/0x200/0x300, run=drain=1 -> three pbs_done pulses 4 cycles apart (LOAD+RUN+DRAIN+IDLE) in FIFO order; job_id 1,2,3; queue_level 3->0.
- Overflow: DEPTH=4, run=100, 6 pulses while first job runs -> first popped, 4 queued, 1 dropped; overflow=1, user_led[5]=1; clr_status clears it.
- Abort in RUN with 2 queued -> next cycle IDLE, queue_level=0, pbs_aborted pulse, no pbs_done, jobs_done unchanged.
- Zero lengths: run=0, drain=0 -> treated as 1; pbs_done 2 cycles after LOAD.
- Async reset asserted mid-DRAIN -> all outputs 0 immediately without a clock edge; after release, a new start runs as job_id 1.
